workout_scheduler: RTL and testbench



---
 rtl/fitness_pkg.sv | 25 ++
 rtl/workout_scheduler_if.sv | 22 ++
 rtl/workout_fifo.sv | 68 ++++++
 rtl/workout_scheduler.sv | 162 ++++++++++++++++
 tb/tb_workout_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fitness_pkg.sv
// Shared definitions for the workout scheduler: exercise code packing,
// datapath widths and the scheduler state encoding.
package fitness_pkg;

    localparam int CODE_W = 8;

    // {weight[7:5], calories[4:3], MET[2:1], gender[0]}
    localparam int W_MSB = 7;
    localparam int W_LSB = 5;
    localparam int C_MSB = 4;
    localparam int C_LSB = 3;
    localparam int M_MSB = 2;
    localparam int M_LSB = 1;
    localparam int G_BIT = 0;

    localparam int T_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/workout_scheduler_if.sv
// Exercise-code request handshake between the user-input front end (master)
// and the scheduler (slave).
interface workout_scheduler_if;
    import fitness_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [CODE_W-1:0] req_code;

    modport master (
        output req_valid,
        output req_code,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_code,
        output req_ready
    );

endinterface

// File: rtl/workout_fifo.sv
// Synchronous exercise-code FIFO with flush. Exposes the head entry and the
// entry behind it so the scheduler can preload the next code while popping.
module workout_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [W-1:0] head_next,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    assign head      = mem[rd_ptr_reg];
    assign head_next = mem[rd_ptr_reg + AW'(1)];

    // Storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/workout_scheduler.sv
// Sequences buffered exercise codes through the external calc_total datapath,
// counts each exercise's minutes down on min_tick and accumulates session minutes.
module workout_scheduler
    import fitness_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int T_W   = fitness_pkg::T_W,
    parameter  int TOT_W = 12,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    workout_scheduler_if.slave   req,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 min_tick,
    output logic [CODE_W-1:0]    calc_code,
    input  logic [T_W-1:0]       calc_t,
    output logic                 busy,
    output logic [IDX_W-1:0]     cur_idx,
    output logic [T_W-1:0]       remain_min,
    output logic [TOT_W-1:0]     total_min,
    output logic                 ex_done,
    output logic                 sess_done
);

    localparam int SUM_W = ((TOT_W > T_W) ? TOT_W : T_W) + 1;
    localparam logic [SUM_W-1:0] TOT_MAX = SUM_W'((64'd1 << TOT_W) - 64'd1);

    sched_state_t        state_reg, state_next;
    logic [CODE_W-1:0]   calc_code_reg, calc_code_next;
    logic [IDX_W-1:0]    cur_idx_reg, cur_idx_next;
    logic [T_W-1:0]      remain_reg, remain_next;
    logic [TOT_W-1:0]    total_reg, total_next;
    logic                ex_done_reg, ex_done_next;
    logic                sess_done_reg, sess_done_next;

    logic                req_ready_int;
    logic                accept;
    logic                start_ok;
    logic                finish;
    logic [CODE_W-1:0]   fifo_head;
    logic [CODE_W-1:0]   fifo_head_next;
    logic                fifo_full;
    logic                fifo_empty;
    logic [IDX_W:0]      fifo_count;
    logic [SUM_W-1:0]    sum_full;
    logic [TOT_W-1:0]    total_sat;

    workout_fifo #(
        .DEPTH (DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (accept),
        .push_data (req.req_code),
        .pop       (finish),
        .head      (fifo_head),
        .head_next (fifo_head_next),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Ready is gated by rst_n so the front end never sees a stale accept during reset.
    assign req_ready_int = rst_n && (state_reg == IDLE) && !fifo_full;
    assign req.req_ready = req_ready_int;

    assign accept   = req.req_valid && req_ready_int && !abort;
    assign start_ok = (state_reg == IDLE) && start && !abort && (!fifo_empty || accept);
    assign finish   = (state_reg == RUN) && !abort &&
                      ((remain_reg == '0) || (min_tick && (remain_reg == T_W'(1))));

    assign sum_full  = SUM_W'(total_reg) + SUM_W'(calc_t);
    assign total_sat = (sum_full > TOT_MAX) ? TOT_MAX[TOT_W-1:0] : sum_full[TOT_W-1:0];

    always_comb begin
        state_next     = state_reg;
        calc_code_next = calc_code_reg;
        cur_idx_next   = cur_idx_reg;
        remain_next    = remain_reg;
        total_next     = total_reg;
        ex_done_next   = 1'b0;
        sess_done_next = 1'b0;

        if (abort) begin
            state_next  = IDLE;
            remain_next = '0;
            cur_idx_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        state_next   = LOAD;
                        total_next   = '0;
                        cur_idx_next = '0;
                        // An entry enqueued in the start cycle is not yet in storage.
                        calc_code_next = fifo_empty ? req.req_code : fifo_head;
                    end
                end
                LOAD: begin
                    remain_next = calc_t;
                    total_next  = total_sat;
                    state_next  = RUN;
                end
                RUN: begin
                    if (finish) begin
                        ex_done_next = 1'b1;
                        cur_idx_next = cur_idx_reg + IDX_W'(1);
                        remain_next  = '0;
                        if (fifo_count == (IDX_W+1)'(1)) begin
                            state_next     = DONE;
                            sess_done_next = 1'b1;
                        end else begin
                            state_next     = LOAD;
                            calc_code_next = fifo_head_next;
                        end
                    end else if (min_tick) begin
                        remain_next = remain_reg - T_W'(1);
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            calc_code_reg <= '0;
            cur_idx_reg   <= '0;
            remain_reg    <= '0;
            total_reg     <= '0;
            ex_done_reg   <= 1'b0;
            sess_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            calc_code_reg <= calc_code_next;
            cur_idx_reg   <= cur_idx_next;
            remain_reg    <= remain_next;
            total_reg     <= total_next;
            ex_done_reg   <= ex_done_next;
            sess_done_reg <= sess_done_next;
        end
    end

    assign busy       = (state_reg != IDLE);
    assign calc_code  = calc_code_reg;
    assign cur_idx    = cur_idx_reg;
    assign remain_min = remain_reg;
    assign total_min  = total_reg;
    assign ex_done    = ex_done_reg;
    assign sess_done  = sess_done_reg;

endmodule

// File: tb/tb_workout_scheduler.sv
// Scoreboard bench for workout_scheduler: calc_total is stubbed by a code->minutes
// table; a second instance with a 10-bit accumulator exercises saturation.
module tb_workout_scheduler;
    import fitness_pkg::*;

    localparam int IDX_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic min_tick = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  calc_code, calc_code10;
    logic [8:0]  calc_t, calc_t10;
    logic        busy, busy10;
    logic [1:0]  cur_idx, cur_idx10;
    logic [8:0]  remain_min, remain10;
    logic [11:0] total_min;
    logic [9:0]  total10;
    logic        ex_done, ex10, sess_done, sess10;

    logic [8:0] t_tab [256];

    assign calc_t   = t_tab[calc_code];
    assign calc_t10 = t_tab[calc_code10];

    workout_scheduler_if req_if();
    workout_scheduler_if req_if10();

    assign req_if10.req_valid = req_if.req_valid;
    assign req_if10.req_code  = req_if.req_code;

    workout_scheduler #(.DEPTH(4), .T_W(9), .TOT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .req(req_if), .start(start), .abort(abort),
        .min_tick(min_tick), .calc_code(calc_code), .calc_t(calc_t), .busy(busy),
        .cur_idx(cur_idx), .remain_min(remain_min), .total_min(total_min),
        .ex_done(ex_done), .sess_done(sess_done)
    );

    workout_scheduler #(.DEPTH(4), .T_W(9), .TOT_W(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .req(req_if10), .start(start), .abort(abort),
        .min_tick(min_tick), .calc_code(calc_code10), .calc_t(calc_t10), .busy(busy10),
        .cur_idx(cur_idx10), .remain_min(remain10), .total_min(total10),
        .ex_done(ex10), .sess_done(sess10)
    );

    typedef struct {
        logic [7:0] code;
        int         t;
        int         idx;
        int         total;
        bit         last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_rec;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   sess_cnt = 0;
    bit   sess_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    // Exercise-completion monitor: pops one expected record per ex_done pulse.
    logic [7:0]       code_prev = '0;
    logic [IDX_W-1:0] idx_prev = '0;
    int               ticks_cur = 0;

    always @(negedge clk) begin
        if (!rst_n || abort) begin
            ticks_cur = 0;
        end else begin
            if (min_tick && remain_min != 0) ticks_cur++;
            if (ex_done) begin
                if (exp_q.size() == 0) begin
                    chk("ex_unexpected", 32'(ex_done), 32'd0);
                end else begin
                    mon_rec = exp_q.pop_front();
                    chk("ex_code",  32'(code_prev), 32'(mon_rec.code));
                    chk("ex_ticks", 32'(ticks_cur), 32'(mon_rec.t));
                    chk("ex_idx",   32'(idx_prev),  32'(mon_rec.idx));
                    chk("ex_total", 32'(total_min), 32'(mon_rec.total));
                    chk("ex_last",  32'(sess_done), 32'(mon_rec.last));
                end
                ticks_cur = 0;
            end else if (sess_done) begin
                chk("sess_alone", 32'(sess_done), 32'd0);
            end
            if (sess_done) begin
                sess_cnt++;
                sess_seen = 1'b1;
            end
        end
        code_prev = calc_code;
        idx_prev  = cur_idx;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c);
        int n = 0;
        req_if.req_valid = 1'b1;
        req_if.req_code  = c;
        @(negedge clk);
        while (!req_if.req_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (req_if.req_ready) begin
            exp_q.push_back('{code: c, t: int'(t_tab[c]), idx: 0, total: 0, last: 1'b0});
        end else begin
            chk("push_timeout", 32'(req_if.req_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        req_if.req_valid = 1'b0;
    endtask

    // Expected index, running total (12-bit saturating) and last flag per entry.
    task automatic finalize_session();
        int tot = 0;
        foreach (exp_q[i]) begin
            tot = (tot + exp_q[i].t > 4095) ? 4095 : tot + exp_q[i].t;
            exp_q[i].idx   = i % 4;
            exp_q[i].total = tot;
            exp_q[i].last  = (i == exp_q.size() - 1);
        end
        sess_seen = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        finalize_session();
        cyc();
        start = 1'b0;
    endtask

    task automatic run_ticks(input int budget);
        int n = 0;
        while (!sess_seen && n < budget) begin
            min_tick = (remain_min != 0) && ($urandom_range(0, 3) != 0);
            cyc();
            n++;
        end
        min_tick = 1'b0;
        chk("sess_reached", 32'(sess_seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int saved;
        bit found;
        foreach (t_tab[i]) t_tab[i] = '0;
        req_if.req_valid = 1'b0;
        req_if.req_code  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_if.req_ready), 32'd0);
        chk("rst_outs", 32'({busy, cur_idx, remain_min, ex_done, sess_done, calc_code}), 32'd0);
        chk("rst_total", 32'(total_min), 32'd0);
        chk("rst10_outs", 32'({busy10, cur_idx10, remain10, ex10, sess10, calc_code10,
                               req_if10.req_ready}), 32'd0);
        chk("rst10_total", 32'(total10), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("rel_req_ready", 32'(req_if.req_ready), 32'd1);

        // 1: single exercise, T=3
        t_tab[8'hA5] = 9'd3;
        push(8'hA5);
        do_start();
        cyc();
        chk("t1_latency_remain", 32'(remain_min), 32'd3);
        chk("t1_calc_code", 32'(calc_code), 32'hA5);
        for (int k = 2; k >= 0; k--) begin
            min_tick = 1'b1;
            cyc();
            min_tick = 1'b0;
            chk("t1_remain", 32'(remain_min), 32'(k));
        end
        chk("t1_ex_sess_done", 32'({ex_done, sess_done}), 32'd3);
        chk("t1_total", 32'(total_min), 32'd3);
        cyc();
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: four exercises incl. T=0, buffer full
        t_tab[8'h11] = 9'd2;
        t_tab[8'h22] = 9'd5;
        t_tab[8'h33] = 9'd0;
        t_tab[8'h44] = 9'd1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        chk("t2_full_ready", 32'(req_if.req_ready), 32'd0);
        req_if.req_valid = 1'b1;
        req_if.req_code  = 8'h55;
        repeat (3) cyc();
        chk("t2_full_hold", 32'(req_if.req_ready), 32'd0);
        req_if.req_valid = 1'b0;
        saved = sess_cnt;
        do_start();
        run_ticks(400);
        cyc();
        chk("t2_total", 32'(total_min), 32'd8);
        chk("t2_one_sess", 32'(sess_cnt - saved), 32'd1);
        chk("t2_idle", 32'(busy), 32'd0);

        // 3: abort during the second of three exercises
        t_tab[8'h61] = 9'd2;
        t_tab[8'h62] = 9'd4;
        t_tab[8'h63] = 9'd3;
        push(8'h61);
        push(8'h62);
        push(8'h63);
        do_start();
        n = 0;
        found = 1'b0;
        while (!found && n < 100) begin
            if (cur_idx == 2'd1 && remain_min == 9'd2) begin
                found = 1'b1;
            end else begin
                min_tick = (remain_min != 0);
                cyc();
                n++;
            end
        end
        min_tick = 1'b0;
        chk("t3_reached_mid", 32'(found), 32'd1);
        saved = sess_cnt;
        abort = 1'b1;
        exp_q.delete();
        cyc();
        abort = 1'b0;
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_remain_idx", 32'({remain_min, cur_idx}), 32'd0);
        chk("t3_total_hold", 32'(total_min), 32'd6);
        repeat (3) cyc();
        chk("t3_no_sess", 32'(sess_cnt - saved), 32'd0);

        // 4: start with an empty (flushed) buffer is ignored
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t4_empty_start_c1", 32'(busy), 32'd0);
        cyc();
        chk("t4_empty_start_c2", 32'(busy), 32'd0);
        // enqueue and start in the same cycle
        t_tab[8'h5A] = 9'd1;
        req_if.req_valid = 1'b1;
        req_if.req_code  = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        chk("t4_ready", 32'(req_if.req_ready), 32'd1);
        exp_q.push_back('{code: 8'h5A, t: 1, idx: 0, total: 0, last: 1'b0});
        finalize_session();
        cyc();
        req_if.req_valid = 1'b0;
        start = 1'b0;
        chk("t4_busy_code", 32'({busy, calc_code}), 32'h15A);
        run_ticks(100);
        cyc();
        chk("t4_total", 32'(total_min), 32'd1);

        // 5: saturation of the session accumulator
        t_tab[8'hFF] = 9'd511;
        repeat (4) push(8'hFF);
        do_start();
        run_ticks(8000);
        cyc();
        chk("t5_total12", 32'(total_min), 32'd2044);
        chk("t5_total10_sat", 32'(total10), 32'd1023);

        // 6: asynchronous reset mid-RUN
        t_tab[8'h77] = 9'd5;
        push(8'h77);
        do_start();
        cyc();
        min_tick = 1'b1;
        cyc();
        min_tick = 1'b0;
        chk("t6_running", 32'(remain_min), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_outs", 32'({busy, cur_idx, remain_min, ex_done, sess_done, calc_code}), 32'd0);
        chk("t6_async_total", 32'(total_min), 32'd0);
        chk("t6_async_ready", 32'(req_if.req_ready), 32'd0);
        exp_q.delete();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t6_rel_ready", 32'(req_if.req_ready), 32'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("t6_buffer_empty", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
